// File: rtl/sync_pkg.sv
// Shared constants and helpers for the sync_debounce input conditioner.
package sync_pkg;

  localparam int SYNC_MIN_STAGES = 2;
  localparam int DB_MIN_CYCLES   = 1;

  // Counter must hold 0..DB_CYCLES-1; sized for DB_CYCLES+1 so DB_CYCLES=1 still gets one bit.
  function automatic int cnt_w(input int db_cycles);
    return $clog2(db_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Single-bit STAGES-deep flip-flop synchronizer with async active-low reset.
module sync_chain
  import sync_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s <= '0;
    end else begin
      r_s <= {r_s[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_s[STAGES-1];

endmodule

// File: rtl/sync_debounce.sv
// Multi-channel synchronizer + optional debounce filter with registered edge pulses.
// Filter is built only when SYNC_DEBOUNCE_FILTER_EN is defined; otherwise level follows sync_q.
module sync_debounce
  import sync_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int STAGES    = 2,
  parameter int DB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_edge
);

  if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
    $error("sync_debounce: STAGES below minimum");
  end
  if (DB_CYCLES < DB_MIN_CYCLES) begin : g_bad_db
    $error("sync_debounce: DB_CYCLES below minimum");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("sync_debounce: WIDTH below minimum");
  end

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_level_nxt;
  logic [WIDTH-1:0] r_level;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sync_chain #(
      .STAGES(STAGES)
    ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .i_d  (async_in[i]),
      .o_q  (w_sync[i])
    );

`ifdef SYNC_DEBOUNCE_FILTER_EN
    localparam int CW = cnt_w(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_nxt;

    // Any cycle where sync_q agrees with level discards the partial count.
    always_comb begin
      w_cnt_nxt = r_cnt;
      w_nxt     = r_level[i];
      if (w_sync[i] == r_level[i]) begin
        w_cnt_nxt = '0;
      end else if (r_cnt == CNT_LAST) begin
        w_nxt     = w_sync[i];
        w_cnt_nxt = '0;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_nxt;
      end
    end

    assign w_level_nxt[i] = w_nxt;
`else
    assign w_level_nxt[i] = w_sync[i];
`endif
  end

  // Pulses are derived from the same next-level value so they coincide with the level change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
    end else begin
      r_level <= w_level_nxt;
      r_rise  <= w_level_nxt & ~r_level;
      r_fall  <= ~w_level_nxt & r_level;
    end
  end

  assign level    = r_level;
  assign rise     = r_rise;
  assign fall     = r_fall;
  assign any_edge = |(r_rise | r_fall);

endmodule

// File: tb/tb_sync_debounce.sv
// Self-checking bench for sync_debounce: directed scenarios plus randomized channel toggling.
module tb_sync_debounce;

  localparam int WIDTH  = 4;
  localparam int STAGES = 2;
  localparam int DB     = 4;
`ifdef SYNC_DEBOUNCE_FILTER_EN
  localparam int DB_EFF = DB;
`else
  localparam int DB_EFF = 1;
`endif
  localparam int LAT = STAGES + DB_EFF - 1;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] async_in;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             any_edge;

  int checks = 0;
  int errors = 0;

  // Reference model: raw input samples captured per clock edge since reset.
  logic [WIDTH-1:0] samp_q[$];
  logic [WIDTH-1:0] lvl_m;
  logic [WIDTH-1:0] rise_m;
  logic [WIDTH-1:0] fall_m;

  sync_debounce #(
    .WIDTH    (WIDTH),
    .STAGES   (STAGES),
    .DB_CYCLES(DB)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_in(async_in),
    .level   (level),
    .rise    (rise),
    .fall    (fall),
    .any_edge(any_edge)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check4(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    samp_q.delete();
    lvl_m  = '0;
    rise_m = '0;
    fall_m = '0;
  endtask

  // At edge n the filter sees the sample taken STAGES edges earlier; a level flips
  // once the DB_EFF most recent such samples all disagree with it.
  task automatic model_edge(input logic [WIDTH-1:0] a);
    int n;
    int idx;
    logic b;
    logic all_opp;
    samp_q.push_back(a);
    n = samp_q.size() - 1;
    rise_m = '0;
    fall_m = '0;
    for (int ch = 0; ch < WIDTH; ch++) begin
      all_opp = 1'b1;
      for (int k = 0; k < DB_EFF; k++) begin
        idx = n - STAGES - k;
        b = (idx < 0) ? 1'b0 : samp_q[idx][ch];
        if (b == lvl_m[ch]) all_opp = 1'b0;
      end
      if (all_opp) begin
        lvl_m[ch] = ~lvl_m[ch];
        if (lvl_m[ch]) rise_m[ch] = 1'b1;
        else           fall_m[ch] = 1'b1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check4({tag, ".level"}, level, lvl_m);
    check4({tag, ".rise"}, rise, rise_m);
    check4({tag, ".fall"}, fall, fall_m);
    check4({tag, ".any_edge"}, {3'b000, any_edge}, {3'b000, |(rise_m | fall_m)});
  endtask

  // Called at a negedge: drive, let one rising edge happen, then check mid-low-phase.
  task automatic tick(input logic [WIDTH-1:0] a, input string tag);
    async_in = a;
    @(posedge clk);
    model_edge(a);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic check_zero(input string tag);
    check4({tag, ".level"}, level, '0);
    check4({tag, ".rise"}, rise, '0);
    check4({tag, ".fall"}, fall, '0);
    check4({tag, ".any_edge"}, {3'b000, any_edge}, 4'h0);
  endtask

  // Asynchronous reset asserted off-edge; released on a negedge so the next posedge is E0.
  task automatic do_reset(input logic [WIDTH-1:0] a, input int cycles);
    async_in = a;
    #2 rst_n = 1'b0;
    #1 check_zero("rst_async");
    repeat (cycles) @(negedge clk);
    check_zero("rst_hold");
    model_clear();
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick('0, "idle");
  endtask

  initial begin
    int edge_hit;
    int left [WIDTH];
    logic [WIDTH-1:0] cur;

    rst_n    = 1'b0;
    async_in = 4'hF;
    model_clear();
    #3 check_zero("por");
    @(negedge clk);
    @(negedge clk);
    check_zero("por_hold");
    rst_n = 1'b1;

    // All inputs high across reset release: rise on every channel after LAT edges.
    edge_hit = -1;
    for (int e = 0; e < 12; e++) begin
      tick(4'hF, "rel_all");
      if (edge_hit < 0 && level === 4'hF) edge_hit = e;
    end
    check_int("rel_latency", edge_hit, LAT);
    idle(12);

    // Channel 0 step and hold.
    edge_hit = -1;
    for (int e = 0; e < 12; e++) begin
      tick(4'h1, "ch0_step");
      if (edge_hit < 0 && rise[0] === 1'b1) edge_hit = e;
    end
    check_int("ch0_latency", edge_hit, LAT);
    idle(12);

    // Channel 1 short pulse (rejected when filtering).
    for (int e = 0; e < 3; e++) tick(4'h2, "ch1_short");
    idle(12);

    // Channel 2 pulse of exactly DB cycles.
    for (int e = 0; e < 4; e++) tick(4'h4, "ch2_exact");
    idle(12);

    // Channel 3 held high with reset hitting mid-count.
    tick(4'h8, "ch3_pre");
    tick(4'h8, "ch3_pre");
    do_reset(4'h8, 2);
    edge_hit = -1;
    for (int e = 0; e < 12; e++) begin
      tick(4'h8, "ch3_post");
      if (edge_hit < 0 && rise[3] === 1'b1) edge_hit = e;
    end
    check_int("ch3_latency", edge_hit, LAT);
    idle(12);

    // Single-cycle glitch on channel 0.
    tick(4'h1, "ch0_glitch");
    idle(10);

    // Randomized per-channel hold times, with occasional resets.
    cur = '0;
    for (int ch = 0; ch < WIDTH; ch++) left[ch] = $urandom_range(1, 8);
    for (int t = 0; t < 600; t++) begin
      for (int ch = 0; ch < WIDTH; ch++) begin
        left[ch]--;
        if (left[ch] <= 0) begin
          cur[ch]  = ~cur[ch];
          left[ch] = $urandom_range(1, 8);
        end
      end
      tick(cur, "rand");
      if (t % 200 == 199) do_reset(cur, $urandom_range(1, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_debounce.md
# sync_debounce

Multi-channel input conditioner for asynchronous external signals such as buttons, switches and off-board strobes. Each channel passes through a configurable-depth flip-flop synchronizer chain into the `clk` domain. An optional per-channel debounce filter follows the chain. The block produces a filtered level plus single-cycle rising and falling edge pulses. It sits at the top-level pin boundary, ahead of any FSM that consumes external inputs.

## Interface
- `WIDTH`, 4: number of independent channels (≥1).
- `STAGES`, 2: synchronizer flip-flops per channel (≥2).
- `DB_CYCLES`, 4: consecutive synchronized cycles a new value must persist before it is accepted (≥1).
- `clk` input 1: single system clock. All logic is on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `async_in` input WIDTH: asynchronous raw inputs, one bit per channel.
- `level` output WIDTH: debounced, synchronized level per channel.
- `rise` output WIDTH: one-cycle pulse when `level[i]` goes 0→1.
- `fall` output WIDTH: one-cycle pulse when `level[i]` goes 1→0.
- `any_edge` output 1: OR over all bits of `rise | fall`.

## Operation
- Channels are fully independent; there is no cross-channel interaction except `any_edge`.
- Synchronizer chain per channel:
  - `s[0] <= async_in[i]`, then `s[k] <= s[k-1]`.
  - `sync_q = s[STAGES-1]`.
- Debounce per channel uses a counter `cnt` of width `$clog2(DB_CYCLES+1)`:
  - `sync_q == level[i]`: `cnt <= 0`.
  - `sync_q != level[i]` and `cnt < DB_CYCLES-1`: `cnt <= cnt+1`.
  - `sync_q != level[i]` and `cnt == DB_CYCLES-1`: `level[i] <= sync_q`, `cnt <= 0`.
- Glitch rejection: any return of `sync_q` to the current `level[i]` before acceptance clears `cnt`. Partial counts never carry over.
- `cnt` never exceeds `DB_CYCLES-1`; there is no wrap-around.
- Edge pulses are registered:
  - `rise[i]` is asserted in exactly the cycle where `level[i]` first reads 1.
  - `fall[i]` is asserted in exactly the cycle where `level[i]` first reads 0.
  - Both are deasserted in the next cycle.
- `rise[i]` and `fall[i]` are never high together.
- `any_edge` is combinational from the `rise` and `fall` registers.
- Reset (`rst_n` low, at any time, including mid-count):
  - All sync flops, `cnt`, `level`, `rise` and `fall` clear to 0 immediately.
  - `any_edge` therefore reads 0.
- After reset release, an input held at 1 is treated as a normal 0→1 transition and produces a `rise` pulse.

## Timing
- Edge E0 is the first `clk` edge that captures a new `async_in[i]` value into `s[0]`.
- `sync_q` shows the new value after edge E0+STAGES-1.
- `level[i]`, `rise[i]` and `fall[i]` update at edge E0+STAGES+DB_CYCLES-1.
  - Defaults: 5 edges after E0.
- Minimum accepted pulse width: DB_CYCLES `clk` cycles of stable synchronized value.
- Shorter pulses produce no output activity.
- Input transitions closer than one clock period may be missed. That is acceptable by design.

## Configuration
- Macro: `SYNC_DEBOUNCE_FILTER_EN`.
- Defined: debounce counters are built as described above.
- Undefined:
  - No counters are instantiated and `DB_CYCLES` is ignored.
  - `level[i] <= sync_q` every cycle, which is behaviourally identical to `DB_CYCLES=1`.
  - Latency from E0 becomes STAGES edges.
  - Edge pulses and reset behaviour are unchanged.

## Structure
- Shared package `sync_pkg` holds:
  - the counter-width function `cnt_w(DB_CYCLES)`;
  - the minimum-value constants `SYNC_MIN_STAGES=2` and `DB_MIN_CYCLES=1`, which are checked at elaboration.
- Sub-module `sync_chain`: a single-bit, `STAGES`-deep chain with async active-low reset, instantiated `WIDTH` times by a generate loop.
- Debounce and edge logic live in the top module `sync_debounce`.

## Test plan
All scenarios use `WIDTH=4`, `STAGES=2`, `DB_CYCLES=4`, with the filter macro defined unless stated otherwise.
- Reset with `async_in=4'hF`, then release:
  - During reset, all outputs are 0.
  - `level=4'hF` at edge E0+5; `rise=4'hF` and `any_edge=1` for exactly one cycle.
- Channel 0 steps 0→1 and holds, other channels stay 0:
  - `level[0]` goes high at E0+5 with a one-cycle `rise[0]`.
  - `level[3:1]`, `fall` and the other `rise` bits stay 0.
- Channel 1 goes high for 3 cycles, then low: `level[1]` stays 0, and `rise`, `fall` and `any_edge` never assert.
- Channel 2 goes high for exactly 4 cycles, then low:
  - Accepted: one-cycle `rise[2]` at E0+5.
  - Then a one-cycle `fall[2]` 4 cycles later.
- Channel 3 held high, `rst_n` pulsed low 2 cycles after E0: outputs and counter clear asynchronously, and `rise[3]` occurs 5 edges after the first post-release capture.
- Macro undefined, channel 0 given a 1-cycle high glitch: `level[0]` goes high at E0+2 for one cycle, with `rise[0]` and then `fall[0]` on consecutive cycles.
